// File: rtl/load_buff_unpacker.sv
// Unpacks 32-bit AXI read-stream words into SEW-sized elements and writes them
// one per cycle, lane by lane, into the per-lane vector load buffers.
module load_buff_unpacker #(
  parameter int V_LANE_NUM         = 8,
  parameter int BUFF_DEPTH         = 256,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [2:0]                    cfg_sew,
  input  logic                          ld_start,
  input  logic [31:0]                   ld_elem_cnt,
  output logic                          ld_busy,
  output logic                          ld_done,
  input  logic                          axi_rd_tvalid,
  output logic                          axi_rd_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] axi_rd_tdata,
  output logic [V_LANE_NUM-1:0]         lbuff_wen,
  output logic [$clog2(BUFF_DEPTH)-1:0] lbuff_waddr,
  output logic [31:0]                   lbuff_wdata
);

  localparam int ADDR_W = $clog2(BUFF_DEPTH);
  localparam int LANE_W = (V_LANE_NUM > 1) ? $clog2(V_LANE_NUM) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [1:0]              sew;
  logic [31:0]             elem_total;
  logic [31:0]             elem_cnt;
  logic [31:0]             hold_data;
  logic                    hold_vld;
  logic [1:0]              offset;
  logic [LANE_W-1:0]       lane;
  logic [ADDR_W-1:0]       waddr;

  logic                    start_ok;
  logic                    wr_en;
  logic                    last_in_word;
  logic                    last_elem;
  logic                    accept;
  logic [1:0]              last_off;
  logic                    sew_unused;

  // Element k of a word sits at byte k<<sew; narrower elements are zero-extended.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [1:0]  s);
    logic [4:0]  sh;
    logic [31:0] mask;
    sh = 5'({off, 3'b000} << s);
    case (s)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (word >> sh) & mask;
  endfunction

  assign sew_unused   = cfg_sew[2];
  assign start_ok     = (state == IDLE) && ld_start;
  assign wr_en        = (state == RECV) && hold_vld;
  assign last_off     = 2'd3 >> sew;
  assign last_in_word = (offset == last_off);
  assign last_elem    = (elem_cnt == elem_total - 32'd1);

  // Refill only when the held word is drained and more elements are still owed.
  assign axi_rd_tready = (state == RECV) && (!hold_vld || (last_in_word && !last_elem));
  assign accept        = axi_rd_tvalid && axi_rd_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      hold_vld <= 1'b0;
      offset   <= 2'd0;
      lane     <= '0;
      waddr    <= '0;
      elem_cnt <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            hold_vld <= 1'b0;
            offset   <= 2'd0;
            lane     <= '0;
            waddr    <= '0;
            elem_cnt <= 32'd0;
            state    <= (ld_elem_cnt == 32'd0) ? DONE : RECV;
          end
        end
        RECV: begin
          if (wr_en) begin
            elem_cnt <= elem_cnt + 32'd1;
            offset   <= offset + 2'd1;
            if (lane == LANE_W'(V_LANE_NUM - 1)) begin
              lane  <= '0;
              waddr <= (waddr == ADDR_W'(BUFF_DEPTH - 1)) ? '0 : waddr + ADDR_W'(1);
            end else begin
              lane <= lane + LANE_W'(1);
            end
            if (last_elem) begin
              hold_vld <= 1'b0;
              state    <= DONE;
            end else if (last_in_word) begin
              hold_vld <= 1'b0;
            end
          end
          if (accept) begin
            hold_vld <= 1'b1;
            offset   <= 2'd0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Configuration and word storage need no reset: they are only read once qualified.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      sew        <= (cfg_sew[1:0] == 2'd3) ? 2'd2 : cfg_sew[1:0];
      elem_total <= ld_elem_cnt;
    end
    if (accept) hold_data <= axi_rd_tdata[31:0];
  end

  assign ld_busy     = (state == RECV) || (state == DONE);
  assign ld_done     = (state == DONE);
  assign lbuff_wen   = wr_en ? (V_LANE_NUM'(1) << lane) : '0;
  assign lbuff_waddr = waddr;
  assign lbuff_wdata = wr_en ? extract(hold_data, offset, sew) : 32'd0;

endmodule
